// File: rtl/trellis_pd_pkg.sv
// rtl/trellis_pd_pkg.sv - shared widths and arithmetic helpers for the trellis phase detector
package trellis_pd_pkg;

    localparam int SAMPLE_W    = 18;
    localparam int ERR_W       = 8;
    localparam int SCALE_SHIFT = 11;
    localparam int DIFF_W      = SAMPLE_W + 1;

    // Negate, mapping the most negative code to the most positive one instead of wrapping
    function automatic logic signed [SAMPLE_W-1:0] sat_neg(input logic signed [SAMPLE_W-1:0] x);
        logic signed [SAMPLE_W-1:0] r;
        if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            r = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else begin
            r = -x;
        end
        return r;
    endfunction

    // Magnitude as an unsigned value; the most negative code yields 2^(SAMPLE_W-1) exactly
    function automatic logic [SAMPLE_W-1:0] abs_val(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] r;
        if (x[SAMPLE_W-1]) begin
            r = ~x + SAMPLE_W'(1);
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/trellis_pd_avg.sv
// rtl/trellis_pd_avg.sv - error averaging accumulator and symbol counter (TRELLIS_PD_AVERAGE_EN)
`ifdef TRELLIS_PD_AVERAGE_EN
module trellis_pd_avg
    import trellis_pd_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DIFF_W-1:0] d,
    input  logic                     d_valid,
    output logic [ERR_W-1:0]         phase_error,
    output logic                     strobe
);

    localparam int ACC_W = DIFF_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] d_ext;
    logic [CNT_W-1:0]        cnt;
    logic                    close;

    assign d_ext = ACC_W'(d);

    // Window sum: the first symbol of a window reloads the accumulator, the rest add to it
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            cnt   <= '0;
            close <= 1'b0;
        end else begin
            close <= d_valid && (cnt == LAST);
            if (d_valid) begin
                acc <= (cnt == '0) ? d_ext : acc + d_ext;
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Publish the completed window sum, scaled back to the per-symbol error range
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_error <= '0;
            strobe      <= 1'b0;
        end else begin
            strobe <= close;
            if (close) begin
                phase_error <= acc[ACC_W-1 -: ERR_W];
            end
        end
    end

endmodule
`endif

// File: rtl/trellis_phase_detector.sv
// rtl/trellis_phase_detector.sv - decision-directed SOQPSK carrier phase detector, optional averaging via TRELLIS_PD_AVERAGE_EN
module trellis_phase_detector
    import trellis_pd_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] MIN_MAG  = 18'd4096,
    parameter int                  AVG_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       symEn,
    input  logic                       sym2xEn,
    input  logic signed [SAMPLE_W-1:0] iIn,
    input  logic signed [SAMPLE_W-1:0] qIn,
    output logic [ERR_W-1:0]           phaseError,
    output logic                       symEn_phErr
);

    logic signed [SAMPLE_W-1:0] q_hold;
    logic signed [SAMPLE_W-1:0] i_hold;
    logic signed [SAMPLE_W-1:0] q_use;
    logic                       v1;
    logic signed [SAMPLE_W-1:0] t1;
    logic signed [SAMPLE_W-1:0] t2;
    logic                       erase;
    logic                       v2;
    logic signed [DIFF_W-1:0]   d_next;

    // Q rail captured on mid-symbol strobes; I rail and the paired Q captured on the symbol strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            q_hold <= '0;
            i_hold <= '0;
            q_use  <= '0;
            v1     <= 1'b0;
        end else begin
            if (sym2xEn && !symEn) begin
                q_hold <= qIn;
            end
            if (symEn) begin
                i_hold <= iIn;
                q_use  <= q_hold;
            end
            v1 <= symEn;
        end
    end

    // Sign-decision cross terms and the small-signal erasure flag
    always_ff @(posedge clk) begin
        if (reset) begin
            t1    <= '0;
            t2    <= '0;
            erase <= 1'b0;
            v2    <= 1'b0;
        end else begin
            t1    <= i_hold[SAMPLE_W-1] ? sat_neg(q_use) : q_use;
            t2    <= q_use[SAMPLE_W-1] ? sat_neg(i_hold) : i_hold;
            erase <= (abs_val(i_hold) < MIN_MAG) && (abs_val(q_use) < MIN_MAG);
            v2    <= v1;
        end
    end

    // Widened difference cannot overflow; erased symbols contribute zero
    always_comb begin
        d_next = '0;
        if (!erase) begin
            d_next = {t1[SAMPLE_W-1], t1} - {t2[SAMPLE_W-1], t2};
        end
    end

`ifdef TRELLIS_PD_AVERAGE_EN
    trellis_pd_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk         (clk),
        .reset       (reset),
        .d           (d_next),
        .d_valid     (v2),
        .phase_error (phaseError),
        .strobe      (symEn_phErr)
    );
`else
    logic [ERR_W-1:0]       d_q;
    logic                   v3;
    logic [SCALE_SHIFT-1:0] unused_d_lsb;
    logic [4:0]             unused_avg_log2;

    assign unused_d_lsb    = d_next[SCALE_SHIFT-1:0];
    assign unused_avg_log2 = AVG_LOG2[4:0];

    // Register the scaled difference, then publish it with a single-cycle strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q         <= '0;
            v3          <= 1'b0;
            phaseError  <= '0;
            symEn_phErr <= 1'b0;
        end else begin
            d_q         <= d_next[DIFF_W-1 -: ERR_W];
            v3          <= v2;
            symEn_phErr <= v3;
            if (v3) begin
                phaseError <= d_q;
            end
        end
    end
`endif

endmodule
